ilocal_mem_arbiter: RTL and testbench

Arbitrates one single-port instruction local memory (BRAM) between two requesters: the fetch stage (port 0, read-only) and a data-side/loader port (port 1, read/write). Grants at most one access per cycle and tracks the owner of each in-flight read through a fixed-latency tag pipeline, so each requester receives only its own read data. Honours a fetch abort so that no stale fetch data is returned after a fetch flush. Sits between the fetch sub-unit layer and the instruction BRAM.

---
 rtl/ilmem_arb_pkg.sv | 22 ++
 rtl/ilmem_tag_pipe.sv | 44 ++++
 rtl/ilocal_mem_arbiter.sv | 99 +++++++++
 tb/tb_ilocal_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ilmem_arb_pkg.sv
// Shared types for the instruction local-memory arbiter: read-tag layout and owner encoding.
package ilmem_arb_pkg;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_DATA  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;

  // Drop a fetch-owned tag when a fetch abort is active; port-1 tags pass unchanged.
  function automatic tag_t kill_fetch(tag_t t, logic abort);
    tag_t r;
    r = t;
    if (abort && (t.owner == OWNER_FETCH)) begin
      r.valid = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ilmem_tag_pipe.sv
// Fixed-latency {valid, owner} shift register that follows each BRAM read to its response cycle.
module ilmem_tag_pipe
  import ilmem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load_valid,
  input  logic load_owner,
  input  logic clr_fetch,
  output logic out_valid,
  output logic out_owner
);

  tag_t stage_q [READ_LATENCY];
  tag_t stage_d [READ_LATENCY];
  tag_t out_tag;

  always_comb begin
    stage_d[0] = '{valid: load_valid, owner: load_owner};
    for (int i = 1; i < READ_LATENCY; i++) begin
      stage_d[i] = kill_fetch(stage_q[i-1], clr_fetch);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  // The abort also masks the entry being presented this very cycle.
  assign out_tag   = kill_fetch(stage_q[READ_LATENCY-1], clr_fetch);
  assign out_valid = out_tag.valid;
  assign out_owner = out_tag.owner;

endmodule

// File: rtl/ilocal_mem_arbiter.sv
// Two-port arbiter for the single-port instruction BRAM (fetch read-only, port 1 read/write).
// Optional anti-starvation for port 1 is enabled by defining ILMEM_ARB_STARVE_EN.
module ilocal_mem_arbiter
  import ilmem_arb_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  input  logic              f_abort,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic force_d;
  logic load_valid;
  logic load_owner;
  logic tag_valid;
  logic tag_owner;

`ifdef ILMEM_ARB_STARVE_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  // Qualified by d_req so a stale full count never blocks an uncontended fetch.
  assign force_d = d_req && (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (d_ready || !d_req) begin
      starve_d = '0;
    end else if (f_req && f_ready && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign force_d = 1'b0;
`endif

  assign f_ready   = f_req & ~force_d;
  assign d_ready   = d_req & (~f_req | force_d);

  assign mem_en    = f_ready | d_ready;
  assign mem_addr  = f_ready ? f_addr : d_addr;
  assign mem_wdata = d_wdata;
  assign mem_we    = (d_ready && d_we) ? d_be : 4'b0000;

  // Aborted fetch grants still read the BRAM, they just never get a tag.
  assign load_valid = (f_ready & ~f_abort) | (d_ready & ~d_we);
  assign load_owner = d_ready ? OWNER_DATA : OWNER_FETCH;

  ilmem_tag_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_owner(load_owner),
    .clr_fetch (f_abort),
    .out_valid (tag_valid),
    .out_owner (tag_owner)
  );

  assign f_rvalid = tag_valid & (tag_owner == OWNER_FETCH);
  assign d_rvalid = tag_valid & (tag_owner == OWNER_DATA);
  assign f_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_ilocal_mem_arbiter.sv
// Directed bench: one arbiter at read latency 1 (a_*) and one at latency 2 (b_*), shared inputs.
module tb_ilocal_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [9:0]  f_addr;
  logic        f_abort;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [9:0]  d_addr;
  logic [31:0] d_wdata;

  logic        a_f_ready, a_f_rvalid, a_d_ready, a_d_rvalid, a_mem_en;
  logic [31:0] a_f_rdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_we;
  logic [9:0]  a_mem_addr;

  logic        b_f_ready, b_f_rvalid, b_d_ready, b_d_rvalid, b_mem_en;
  logic [31:0] b_f_rdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_we;
  logic [9:0]  b_mem_addr;

  int checks;
  int errors;
  logic [9:0] exp_d;

  ilocal_mem_arbiter #(.READ_LATENCY(1), .ADDR_W(10), .STARVE_LIMIT(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ready(a_f_ready), .f_abort(f_abort),
    .f_rvalid(a_f_rvalid), .f_rdata(a_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(a_d_ready), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  ilocal_mem_arbiter #(.READ_LATENCY(2), .ADDR_W(10), .STARVE_LIMIT(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ready(b_f_ready), .f_abort(f_abort),
    .f_rvalid(b_f_rvalid), .f_rdata(b_f_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // BRAM models: byte-enabled write, registered read (plus one extra stage for b).
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] rd_b1;

  always @(posedge clk) begin
    if (a_mem_en) begin
      for (int i = 0; i < 4; i++) if (a_mem_we[i]) mem_a[a_mem_addr][8*i +: 8] <= a_mem_wdata[8*i +: 8];
      a_mem_rdata <= mem_a[a_mem_addr];
    end
    if (b_mem_en) begin
      for (int i = 0; i < 4; i++) if (b_mem_we[i]) mem_b[b_mem_addr][8*i +: 8] <= b_mem_wdata[8*i +: 8];
      rd_b1 <= mem_b[b_mem_addr];
    end
    b_mem_rdata <= rd_b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    f_req = 0; f_abort = 0; d_req = 0; d_we = 0; d_be = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk); f_req = 1; f_addr = 10'h010; #1;
    checks++; if (a_f_ready !== 1'b1) begin errors++; $display("FAIL rst_f_ready: got %b want 1", a_f_ready); end
    checks++; if (a_mem_addr !== 10'h010) begin errors++; $display("FAIL rst_mem_addr: got %h want 010", a_mem_addr); end
    checks++; if (a_f_rvalid !== 1'b0 || a_d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_a_rvalid: got %b%b want 00", a_f_rvalid, a_d_rvalid); end
    @(negedge clk); f_req = 0; #1;
    checks++; if (a_f_rvalid !== 1'b0) begin errors++; $display("FAIL rst_held_rvalid: got %b want 0", a_f_rvalid); end
    rst = 1;
    @(negedge clk); #1;
    checks++; if (b_f_rvalid !== 1'b0 || b_d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_b_rvalid: got %b%b want 00", b_f_rvalid, b_d_rvalid); end
  endtask

  task automatic test_fetch_read;
    @(negedge clk); f_req = 1; f_addr = 10'h010; #1;
    checks++; if (a_f_ready !== 1'b1 || a_mem_en !== 1'b1 || a_mem_we !== 4'b0) begin errors++; $display("FAIL fr_grant: got rdy=%b en=%b we=%b want 1 1 0000", a_f_ready, a_mem_en, a_mem_we); end
    @(negedge clk); f_req = 0; #1;
    checks++; if (a_f_rvalid !== 1'b1 || a_f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fr_a_resp: got v=%b d=%h want 1 deadbeef", a_f_rvalid, a_f_rdata); end
    checks++; if (a_d_rvalid !== 1'b0 || b_f_rvalid !== 1'b0) begin errors++; $display("FAIL fr_no_other: got a_d=%b b_f=%b want 0 0", a_d_rvalid, b_f_rvalid); end
    @(negedge clk); #1;
    checks++; if (b_f_rvalid !== 1'b1 || b_f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fr_b_resp: got v=%b d=%h want 1 deadbeef", b_f_rvalid, b_f_rdata); end
    checks++; if (a_f_rvalid !== 1'b0) begin errors++; $display("FAIL fr_a_single: got %b want 0", a_f_rvalid); end
  endtask

  task automatic test_contention;
    @(negedge clk); f_req = 1; f_addr = 10'h010; d_req = 1; d_we = 0; d_addr = 10'h020; #1;
    checks++; if (a_f_ready !== 1'b1 || a_d_ready !== 1'b0 || a_mem_addr !== 10'h010) begin errors++; $display("FAIL ct_fetch_wins: got f=%b d=%b a=%h want 1 0 010", a_f_ready, a_d_ready, a_mem_addr); end
    @(negedge clk); f_req = 0; #1;
    checks++; if (a_d_ready !== 1'b1 || a_mem_addr !== 10'h020) begin errors++; $display("FAIL ct_d_grant: got d=%b a=%h want 1 020", a_d_ready, a_mem_addr); end
    checks++; if (a_f_rvalid !== 1'b1 || a_d_rvalid !== 1'b0) begin errors++; $display("FAIL ct_f_resp: got f=%b d=%b want 1 0", a_f_rvalid, a_d_rvalid); end
    @(negedge clk); d_req = 0; #1;
    checks++; if (a_d_rvalid !== 1'b1 || a_d_rdata !== 32'hCAFEF00D || a_f_rvalid !== 1'b0) begin errors++; $display("FAIL ct_d_resp: got dv=%b d=%h fv=%b want 1 cafef00d 0", a_d_rvalid, a_d_rdata, a_f_rvalid); end
  endtask

  task automatic test_write_read;
    @(negedge clk); d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 10'h030; d_wdata = 32'h0000ABCD; #1;
    checks++; if (a_mem_we !== 4'b0011 || a_d_ready !== 1'b1 || a_mem_addr !== 10'h030) begin errors++; $display("FAIL wr_issue: got we=%b rdy=%b a=%h want 0011 1 030", a_mem_we, a_d_ready, a_mem_addr); end
    checks++; if (a_mem_wdata !== 32'h0000ABCD) begin errors++; $display("FAIL wr_wdata: got %h want 0000abcd", a_mem_wdata); end
    @(negedge clk); d_req = 0; d_we = 0; d_be = 0; f_req = 1; f_addr = 10'h030; #1;
    checks++; if (a_d_rvalid !== 1'b0 || a_f_rvalid !== 1'b0 || a_mem_we !== 4'b0) begin errors++; $display("FAIL wr_no_resp: got d=%b f=%b we=%b want 0 0 0000", a_d_rvalid, a_f_rvalid, a_mem_we); end
    @(negedge clk); f_req = 0; #1;
    checks++; if (a_f_rvalid !== 1'b1 || a_f_rdata !== 32'h1234ABCD) begin errors++; $display("FAIL wr_readback: got v=%b d=%h want 1 1234abcd", a_f_rvalid, a_f_rdata); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); f_req = 1; f_addr = 10'h010; #1;
    @(negedge clk); f_addr = 10'h020; #1;
    checks++; if (a_f_rvalid !== 1'b1 || a_f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_0: got v=%b d=%h want 1 deadbeef", a_f_rvalid, a_f_rdata); end
    @(negedge clk); f_addr = 10'h030; #1;
    checks++; if (a_f_rvalid !== 1'b1 || a_f_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_1: got v=%b d=%h want 1 cafef00d", a_f_rvalid, a_f_rdata); end
    checks++; if (b_f_rvalid !== 1'b1 || b_f_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_b0: got v=%b d=%h want 1 deadbeef", b_f_rvalid, b_f_rdata); end
    @(negedge clk); f_req = 0; #1;
    checks++; if (a_f_rvalid !== 1'b1 || a_f_rdata !== 32'h1234ABCD) begin errors++; $display("FAIL b2b_2: got v=%b d=%h want 1 1234abcd", a_f_rvalid, a_f_rdata); end
    @(negedge clk); #1;
    checks++; if (a_f_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", a_f_rvalid); end
  endtask

  task automatic test_abort;
    @(negedge clk); d_req = 1; d_we = 0; d_addr = 10'h020; #1;
    checks++; if (b_d_ready !== 1'b1) begin errors++; $display("FAIL ab_d_grant: got %b want 1", b_d_ready); end
    @(negedge clk); d_req = 0; f_req = 1; f_addr = 10'h010; #1;
    @(negedge clk); f_addr = 10'h030; f_abort = 1; #1;
    checks++; if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ab_d_survives: got v=%b d=%h want 1 cafef00d", b_d_rvalid, b_d_rdata); end
    checks++; if (b_f_rvalid !== 1'b0 || a_f_rvalid !== 1'b0) begin errors++; $display("FAIL ab_same_cycle: got b=%b a=%b want 0 0", b_f_rvalid, a_f_rvalid); end
    @(negedge clk); f_req = 0; f_abort = 0; #1;
    checks++; if (b_f_rvalid !== 1'b0 || a_f_rvalid !== 1'b0) begin errors++; $display("FAIL ab_n2: got b=%b a=%b want 0 0", b_f_rvalid, a_f_rvalid); end
    @(negedge clk); #1;
    checks++; if (b_f_rvalid !== 1'b0) begin errors++; $display("FAIL ab_n3: got %b want 0", b_f_rvalid); end
  endtask

  task automatic test_priority;
`ifdef ILMEM_ARB_STARVE_EN
    exp_d = 10'b1000010000;
`else
    exp_d = 10'b0000000000;
`endif
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); f_req = 1; f_addr = 10'h010; d_req = 1; d_we = 0; d_addr = 10'h020; #1;
      checks++;
      if (a_d_ready !== exp_d[i] || a_f_ready !== ~exp_d[i]) begin
        errors++; $display("FAIL prio_cycle%0d: got f=%b d=%b want f=%b d=%b", i, a_f_ready, a_d_ready, ~exp_d[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_reset_inflight;
    @(negedge clk); f_req = 1; f_addr = 10'h010; #1;
    @(negedge clk); f_req = 0; d_req = 1; d_we = 0; d_addr = 10'h020; #1;
    @(negedge clk); d_req = 0; rst = 0; #1;
    checks++; if (b_f_rvalid !== 1'b0 || b_d_rvalid !== 1'b0) begin errors++; $display("FAIL rif_during: got f=%b d=%b want 0 0", b_f_rvalid, b_d_rvalid); end
    @(negedge clk); rst = 1; #1;
    checks++; if (b_f_rvalid !== 1'b0 || b_d_rvalid !== 1'b0) begin errors++; $display("FAIL rif_release: got f=%b d=%b want 0 0", b_f_rvalid, b_d_rvalid); end
    @(negedge clk); #1;
    checks++; if (b_f_rvalid !== 1'b0 || b_d_rvalid !== 1'b0 || a_d_rvalid !== 1'b0) begin errors++; $display("FAIL rif_after: got bf=%b bd=%b ad=%b want 0 0 0", b_f_rvalid, b_d_rvalid, a_d_rvalid); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 0; f_req = 0; f_addr = 0; f_abort = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 32'h0; mem_b[i] = 32'h0;
    end
    mem_a[10'h010] = 32'hDEADBEEF; mem_b[10'h010] = 32'hDEADBEEF;
    mem_a[10'h020] = 32'hCAFEF00D; mem_b[10'h020] = 32'hCAFEF00D;
    mem_a[10'h030] = 32'h12345678; mem_b[10'h030] = 32'h12345678;
    a_mem_rdata = 0; b_mem_rdata = 0; rd_b1 = 0;

    test_reset();
    idle(3);
    test_fetch_read();
    idle(3);
    test_contention();
    idle(3);
    test_write_read();
    idle(3);
    test_back_to_back();
    idle(3);
    test_abort();
    idle(3);
    test_priority();
    idle(3);
    test_reset_inflight();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
